// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types, constants and digit-enable helper for the segment scanner
package seg_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic logic [3:0] an_onecold(input logic [1:0] idx);
    logic [3:0] one;
    one = 4'b0001 << idx;
    return ~one;
  endfunction

endpackage

// File: rtl/scan_div.sv
// rtl/scan_div.sv - slot prescaler counting 0..DIV-1 with a wrap pulse on the last count
module scan_div #(
  parameter int DIV = 10,
  parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clock_50,
  input  logic          rs_n,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  assign wrap = en && (count == CW'(DIV - 1));

  // Held at zero while disabled so a re-enable always begins a fresh slot.
  always_ff @(posedge clock_50 or negedge rs_n) begin
    if (!rs_n) begin
      count <= '0;
    end else if (!en || wrap) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - 4-digit multiplexed 7-segment scanner with per-slot blanking
// Optional brightness control: define SEG_SCAN_DIM_EN to add the dim[1:0] input.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clock_50,
  input  logic       rs_n,
  input  logic       en,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  input  logic [6:0] hex2,
  input  logic [6:0] hex3,
`ifdef SEG_SCAN_DIM_EN
  input  logic [1:0] dim,
`endif
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int DIV       = CLK_HZ / SCAN_HZ;
  localparam int CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DRIVE_CYC = DIV - BLANK_CYC;

  if (DIV < BLANK_CYC + 4 || SCAN_HZ > CLK_HZ) begin : g_bad_cfg
    $error("seg_scan_mux: slot too short for blanking or scan rate above clock rate");
  end

  logic [CW-1:0] count;
  logic          wrap;

  scan_div #(
    .DIV(DIV),
    .CW (CW)
  ) u_div (
    .clock_50(clock_50),
    .rs_n    (rs_n),
    .en      (en),
    .count   (count),
    .wrap    (wrap)
  );

  logic [1:0]  idx;
  logic [6:0]  shadow [4];
  logic        load;
  logic [6:0]  pat_now;
  logic [CW:0] count_x;
  logic        in_blank;
  logic        in_window;
  logic [CW:0] lit_end;

  localparam logic [CW:0] BLANK_W = (CW+1)'(BLANK_CYC);

  // First cycle of every frame, including the first one after enable.
  assign load    = en && (count == '0) && (idx == 2'd0);
  assign pat_now = load ? hex0 : shadow[idx];
  assign count_x = {1'b0, count};
  assign in_blank  = count_x < BLANK_W;
  assign in_window = count_x < lit_end;

`ifdef SEG_SCAN_DIM_EN
  localparam logic [CW:0] END0 = (CW+1)'(BLANK_CYC + DRIVE_CYC / 4);
  localparam logic [CW:0] END1 = (CW+1)'(BLANK_CYC + (2 * DRIVE_CYC) / 4);
  localparam logic [CW:0] END2 = (CW+1)'(BLANK_CYC + (3 * DRIVE_CYC) / 4);
  localparam logic [CW:0] END3 = (CW+1)'(BLANK_CYC + DRIVE_CYC);

  logic [1:0] dim_q;
  logic [1:0] dim_eff;

  assign dim_eff = load ? dim : dim_q;

  always_comb begin
    lit_end = END3;
    case (dim_eff)
      2'd0:    lit_end = END0;
      2'd1:    lit_end = END1;
      2'd2:    lit_end = END2;
      default: lit_end = END3;
    endcase
  end

  always_ff @(posedge clock_50 or negedge rs_n) begin
    if (!rs_n) begin
      dim_q <= 2'd3;
    end else if (load) begin
      dim_q <= dim;
    end
  end
`else
  assign lit_end = (CW+1)'(DIV);
`endif

  scan_state_t state, state_next;
  logic [6:0]  seg_next;
  logic [3:0]  an_next;
  logic        ft_next;

  always_comb begin
    state_next = BLANK;
    seg_next   = SEG_OFF;
    an_next    = AN_OFF;
    ft_next    = 1'b0;
    case (state)
      BLANK:   state_next = (en && !in_blank) ? DRIVE : BLANK;
      DRIVE:   state_next = (!en || in_blank) ? BLANK : DRIVE;
      default: state_next = BLANK;
    endcase
    if (en) begin
      ft_next = wrap && (idx == 2'd3);
      if (state_next == DRIVE && in_window) begin
        seg_next = pat_now;
        an_next  = an_onecold(idx);
      end
    end
  end

  always_ff @(posedge clock_50 or negedge rs_n) begin
    if (!rs_n) begin
      state      <= BLANK;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      seg        <= seg_next;
      an         <= an_next;
      frame_tick <= ft_next;
    end
  end

  always_ff @(posedge clock_50 or negedge rs_n) begin
    if (!rs_n) begin
      idx <= 2'd0;
    end else if (!en) begin
      idx <= 2'd0;
    end else if (wrap) begin
      idx <= idx + 2'd1;
    end
  end

  // Inputs are frozen per frame so scrolling text never tears mid-scan.
  always_ff @(posedge clock_50 or negedge rs_n) begin
    if (!rs_n) begin
      shadow[0] <= SEG_OFF;
      shadow[1] <= SEG_OFF;
      shadow[2] <= SEG_OFF;
      shadow[3] <= SEG_OFF;
    end else if (load) begin
      shadow[0] <= hex0;
      shadow[1] <= hex1;
      shadow[2] <= hex2;
      shadow[3] <= hex3;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - scoreboard bench for seg_scan_mux (DIV=10, BLANK_CYC=2)
module tb_seg_scan_mux;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       ft;
  } exp_t;

  logic       clock_50 = 1'b0;
  logic       rs_n = 1'b1;
  logic       en = 1'b0;
  logic [6:0] hex0 = 7'h7F, hex1 = 7'h7F, hex2 = 7'h7F, hex3 = 7'h7F;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;
`ifdef SEG_SCAN_DIM_EN
  logic [1:0] dim = 2'd3;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];
  exp_t e;

  always #5 clock_50 = ~clock_50;

  seg_scan_mux #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2)) dut (
    .clock_50  (clock_50),
    .rs_n      (rs_n),
    .en        (en),
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3),
`ifdef SEG_SCAN_DIM_EN
    .dim       (dim),
`endif
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always @(negedge clock_50) begin
    if (rs_n === 1'b1) begin
      checks++;
      if (an !== 4'b1111 && !$onehot(~an)) begin
        errors++;
        $display("FAIL onecold t=%0t an=%b required all-ones or one low bit", $time, an);
      end
    end
  end

  // Expected outputs for n cycles of scanning from a fresh start; pa is frame 0, pb later frames.
  task automatic push_run(input int n, input logic [3:0][6:0] pa, input logic [3:0][6:0] pb,
                          input int len);
    exp_t x;
    logic [3:0] one;
    for (int k = 0; k < n; k++) begin
      int c, d;
      c = k % 10;
      d = (k / 10) % 4;
      one = 4'b0001 << d;
      if (c >= 2 && c < 2 + len) begin
        x.an  = ~one;
        x.seg = (k < 40) ? pa[d] : pb[d];
      end else begin
        x.an  = 4'b1111;
        x.seg = 7'h7F;
      end
      x.ft = (k % 40 == 39);
      sbq.push_back(x);
    end
  endtask

  task automatic park(input logic [6:0] h0, input logic [6:0] h1, input logic [6:0] h2,
                      input logic [6:0] h3);
    @(negedge clock_50);
    en = 1'b0;
    repeat (2) @(negedge clock_50);
    hex0 = h0; hex1 = h1; hex2 = h2; hex3 = h3;
    en = 1'b1;
  endtask

  task automatic test_reset();
    #2 rs_n = 1'b0;
    #1;
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_async seg=%h an=%b ft=%b required 7f/1111/0", seg, an, frame_tick);
    end
    repeat (2) @(posedge clock_50);
    #1;
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold seg=%h an=%b ft=%b required 7f/1111/0", seg, an, frame_tick);
    end
    @(negedge clock_50) rs_n = 1'b1;
    @(posedge clock_50);
    #1;
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL parked seg=%h an=%b ft=%b required 7f/1111/0", seg, an, frame_tick);
    end
  endtask

  task automatic test_main();
    park(7'h09, 7'h79, 7'h7F, 7'h7F);
    push_run(80, {7'h7F, 7'h7F, 7'h79, 7'h09}, {7'h7F, 7'h7F, 7'h79, 7'h09}, 8);
    for (int k = 0; k < 80; k++) begin
      @(posedge clock_50);
      #1;
      e = sbq.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.ft) begin
        errors++;
        $display("FAIL main k=%0d seg=%h an=%b ft=%b required %h/%b/%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.ft);
      end
    end
  endtask

  task automatic test_mid_frame();
    park(7'h09, 7'h79, 7'h7F, 7'h7F);
    push_run(80, {7'h7F, 7'h7F, 7'h79, 7'h09}, {7'h7F, 7'h7F, 7'h79, 7'h40}, 8);
    for (int k = 0; k < 80; k++) begin
      @(posedge clock_50);
      #1;
      e = sbq.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.ft) begin
        errors++;
        $display("FAIL mid_frame k=%0d seg=%h an=%b ft=%b required %h/%b/%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.ft);
      end
      if (k == 5) hex0 = 7'h40;
    end
  endtask

  task automatic test_en_gap();
    park(7'h12, 7'h24, 7'h30, 7'h19);
    push_run(26, {7'h19, 7'h30, 7'h24, 7'h12}, {7'h19, 7'h30, 7'h24, 7'h12}, 8);
    for (int k = 0; k < 26; k++) begin
      @(posedge clock_50);
      #1;
      e = sbq.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.ft) begin
        errors++;
        $display("FAIL gap_pre k=%0d seg=%h an=%b ft=%b required %h/%b/%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.ft);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) sbq.push_back('{seg: 7'h7F, an: 4'hF, ft: 1'b0});
    for (int k = 0; k < 10; k++) begin
      @(posedge clock_50);
      #1;
      e = sbq.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.ft) begin
        errors++;
        $display("FAIL gap_dark k=%0d seg=%h an=%b ft=%b required %h/%b/%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.ft);
      end
    end
    en = 1'b1;
    push_run(15, {7'h19, 7'h30, 7'h24, 7'h12}, {7'h19, 7'h30, 7'h24, 7'h12}, 8);
    for (int k = 0; k < 15; k++) begin
      @(posedge clock_50);
      #1;
      e = sbq.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.ft) begin
        errors++;
        $display("FAIL gap_resume k=%0d seg=%h an=%b ft=%b required %h/%b/%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.ft);
      end
    end
  endtask

  task automatic test_async_reset();
    park(7'h02, 7'h78, 7'h00, 7'h10);
    for (int k = 0; k < 6; k++) @(posedge clock_50);
    #1;
    checks++;
    if (an !== 4'b1110 || seg !== 7'h02) begin
      errors++;
      $display("FAIL pre_reset_drive seg=%h an=%b required 02/1110", seg, an);
    end
    #2 rs_n = 1'b0;
    #1;
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_slot seg=%h an=%b ft=%b required 7f/1111/0", seg, an, frame_tick);
    end
    repeat (2) @(posedge clock_50);
    @(negedge clock_50) rs_n = 1'b1;
    push_run(20, {7'h10, 7'h00, 7'h78, 7'h02}, {7'h10, 7'h00, 7'h78, 7'h02}, 8);
    for (int k = 0; k < 20; k++) begin
      @(posedge clock_50);
      #1;
      e = sbq.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_tick !== e.ft) begin
        errors++;
        $display("FAIL post_reset k=%0d seg=%h an=%b ft=%b required %h/%b/%b",
                 k, seg, an, frame_tick, e.seg, e.an, e.ft);
      end
    end
  endtask

`ifdef SEG_SCAN_DIM_EN
  task automatic test_dim();
    for (int pass = 0; pass < 2; pass++) begin
      dim = (pass == 0) ? 2'd0 : 2'd3;
      park(7'h24, 7'h30, 7'h19, 7'h12);
      push_run(40, {7'h12, 7'h19, 7'h30, 7'h24}, {7'h12, 7'h19, 7'h30, 7'h24},
               (pass == 0) ? 2 : 8);
      for (int k = 0; k < 40; k++) begin
        @(posedge clock_50);
        #1;
        e = sbq.pop_front();
        checks++;
        if (seg !== e.seg || an !== e.an || frame_tick !== e.ft) begin
          errors++;
          $display("FAIL dim%0d k=%0d seg=%h an=%b ft=%b required %h/%b/%b",
                   dim, k, seg, an, frame_tick, e.seg, e.an, e.ft);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_main();
    test_mid_frame();
    test_en_gap();
    test_async_reset();
`ifdef SEG_SCAN_DIM_EN
    test_dim();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
